// File: rtl/fact_bus_pkg.sv
// Shared bus map and master state encoding for the factorial accelerator and its bus master.
package fact_bus_pkg;

    localparam logic [1:0] FACT_A_N    = 2'd0;
    localparam logic [1:0] FACT_A_GO   = 2'd1;
    localparam logic [1:0] FACT_A_DONE = 2'd2;
    localparam logic [1:0] FACT_A_RES  = 2'd3;

    localparam int GO_BIT   = 0;
    localparam int DONE_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_N,
        ST_WR_GO,
        ST_POLL,
        ST_RD_RES,
        ST_CLR_GO,
        ST_FIN
    } factState_e;

endpackage

// File: rtl/fact_poll_timer.sv
// Saturating poll-cycle counter with stale-done guard and timeout flags.
module fact_poll_timer #(
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10,
    parameter int MIN_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic at_min,
    output logic at_timeout
);

    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] MIN_CNT = TO_W'(MIN_WAIT);

    logic [TO_W-1:0] count;

    // Holds at TO_MAX so a stuck poll can never wrap back under the guard window.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != TO_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign at_min     = (count >= MIN_CNT);
    assign at_timeout = (count == TO_MAX);

endmodule

// File: rtl/fact_bus_master.sv
// Bus master sequencing one factorial operation: write n, go, poll done, read result, clear go.
module fact_bus_master
    import fact_bus_pkg::*;
#(
    parameter int TIMEOUT  = 1023,
    parameter int TO_W     = 10,
    parameter int MIN_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  n_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [1:0]  A,
    output logic        WE,
    output logic [3:0]  WD,
    input  logic [31:0] RD
);

    factState_e state, nextState;
    logic [3:0] nReg, nOp;
    logic       abortFlag, abortNext;
    logic       timerAtMin, timerAtTimeout;
    logic [1:0] aNext;
    logic       weNext, busyNext, doneNext, errNext;
    logic [3:0] wdNext;

    fact_poll_timer #(
        .TIMEOUT  (TIMEOUT),
        .TO_W     (TO_W),
        .MIN_WAIT (MIN_WAIT)
    ) pollTimer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == ST_WR_GO),
        .enable     (state == ST_POLL),
        .at_min     (timerAtMin),
        .at_timeout (timerAtTimeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            abortFlag <= 1'b0;
        end else begin
            state     <= nextState;
            abortFlag <= abortNext;
        end
    end

    // Operand is latched on the accepting edge, so WR_N must see n_in directly.
    assign nOp = (state == ST_IDLE) ? n_in : nReg;

    always_comb begin
        nextState = state;
        abortNext = abortFlag;
        case (state)
            ST_IDLE:   if (start) begin
                           nextState = ST_WR_N;
                           abortNext = 1'b0;
                       end
            ST_WR_N:   nextState = ST_WR_GO;
            ST_WR_GO:  nextState = ST_POLL;
            ST_POLL:   if (RD[DONE_BIT] && timerAtMin) begin
                           nextState = ST_RD_RES;
                       end else if (timerAtTimeout) begin
                           nextState = ST_CLR_GO;
                           abortNext = 1'b1;
                       end
            ST_RD_RES: nextState = ST_CLR_GO;
            ST_CLR_GO: nextState = ST_FIN;
            ST_FIN:    nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        aNext  = FACT_A_N;
        weNext = 1'b0;
        wdNext = '0;
        case (nextState)
            ST_WR_N:   begin weNext = 1'b1; wdNext = nOp; end
            ST_WR_GO:  begin aNext = FACT_A_GO; weNext = 1'b1; wdNext[GO_BIT] = 1'b1; end
            ST_POLL:   aNext = FACT_A_DONE;
            ST_RD_RES: aNext = FACT_A_RES;
            ST_CLR_GO: begin aNext = FACT_A_GO; weNext = 1'b1; end
            default:   aNext = FACT_A_N;
        endcase
        busyNext = (nextState != ST_IDLE) && (nextState != ST_FIN);
        doneNext = (nextState == ST_FIN) && !abortNext;
        errNext  = (nextState == ST_FIN) && abortNext;
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            nReg <= n_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A      <= FACT_A_N;
            WE     <= 1'b0;
            WD     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            A    <= aNext;
            WE   <= weNext;
            WD   <= wdNext;
            busy <= busyNext;
            done <= doneNext;
            err  <= errNext;
            if (state == ST_RD_RES) begin
                result <= RD;
            end
        end
    end

endmodule

// File: tb/tb_fact_bus_master.sv
// Bench for fact_bus_master against a behavioural accelerator with stuck-done stub modes.
module tb_fact_bus_master;
    import fact_bus_pkg::*;

    localparam int TIMEOUT  = 1023;
    localparam int TO_W     = 10;
    localparam int MIN_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  n_in;
    logic        busy, done, err;
    logic [31:0] result;
    logic [1:0]  A;
    logic        WE;
    logic [3:0]  WD;
    logic [31:0] RD;

    always #5 clk = ~clk;

    fact_bus_master #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .MIN_WAIT(MIN_WAIT)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in),
        .busy(busy), .done(done), .err(err), .result(result),
        .A(A), .WE(WE), .WD(WD), .RD(RD)
    );

    int passCount = 0;
    int checkCount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    endtask

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // Behavioural accelerator: mode 0 real, 1 done stuck high, 2 done stuck low.
    int          stubMode = 0;
    int          accLatency = 3;
    logic [3:0]  accN;
    logic        accGo, accDone, accRun;
    int          accCnt;
    logic [31:0] accRes;

    always @(posedge clk) begin
        if (rst) begin
            accN <= '0; accGo <= 1'b0; accDone <= 1'b0; accRun <= 1'b0; accCnt <= 0; accRes <= '0;
        end else begin
            if (WE && A == FACT_A_N) accN <= WD;
            if (WE && A == FACT_A_GO) begin
                accGo   <= WD[GO_BIT];
                accDone <= 1'b0;
                accRun  <= WD[GO_BIT];
                accCnt  <= accLatency;
            end else if (accRun) begin
                if (accCnt == 0) begin
                    accRun  <= 1'b0;
                    accDone <= 1'b1;
                    accRes  <= fact(int'(accN));
                end else begin
                    accCnt <= accCnt - 1;
                end
            end
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            FACT_A_N:    RD = {28'd0, accN};
            FACT_A_GO:   RD = {31'd0, accGo};
            FACT_A_DONE: RD = (stubMode == 1) ? 32'd1 : (stubMode == 2) ? 32'd0 : {31'd0, accDone};
            default:     RD = (stubMode == 1) ? 32'hCAFEF00D : accRes;
        endcase
    end

    // Watches one operation from the first POLL cycle to its done/err pulse.
    task automatic waitOp(output int pollCnt, output int qualToDone, output int doneCnt,
                          output int errCnt, output logic busyAtEnd, output logic clrSeen,
                          output logic overlap, output logic timedOut);
        int cyc, qualCyc;
        cyc = 0; qualCyc = -1;
        pollCnt = 0; qualToDone = -1; doneCnt = 0; errCnt = 0;
        busyAtEnd = 1'b1; clrSeen = 1'b0; overlap = 1'b0; timedOut = 1'b1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (A == FACT_A_DONE && !WE) begin
                if (pollCnt >= MIN_WAIT && RD[DONE_BIT] && qualCyc < 0) qualCyc = cyc;
                pollCnt++;
            end
            if (A == FACT_A_GO && WE && WD == 4'd0) clrSeen = 1'b1;
            if (done && err) overlap = 1'b1;
            if (done) doneCnt++;
            if (err) errCnt++;
            if (done || err) begin
                busyAtEnd = busy;
                if (qualCyc >= 0) qualToDone = cyc - qualCyc;
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after done.
    task automatic doOp(input logic [3:0] n, input int lat, input logic [31:0] expRes, input string tag);
        int pc, q2d, dc, ec;
        logic be, cs, ov, to;
        accLatency = lat;
        start = 1'b1; n_in = n;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_wrn_bus"}, {A, WE, WD}, {2'd0, 1'b1, n});
        check({tag, "_wrn_busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_wrgo_bus"}, {A, WE, WD}, {2'd1, 1'b1, 4'b0001});
        waitOp(pc, q2d, dc, ec, be, cs, ov, to);
        check({tag, "_finished"}, to, 1'b0);
        check({tag, "_done"}, dc, 1);
        check({tag, "_err"}, ec, 0);
        check({tag, "_busy_at_done"}, be, 1'b0);
        check({tag, "_clr_go"}, cs, 1'b1);
        check({tag, "_latency"}, q2d, 3);
        check({tag, "_result"}, result, expRes);
        @(negedge clk);
        check({tag, "_done_single"}, done, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        logic [3:0]  n;
        int          lat;
        logic [31:0] expRes;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int pc, q2d, dc, ec;
        logic be, cs, ov, to;
        logic [31:0] prevRes;

        vecs[0] = '{4'd5,  3, 32'd120};
        vecs[1] = '{4'd0,  0, 32'd1};
        vecs[2] = '{4'd12, 7, 32'd479001600};
        vecs[3] = '{4'd1,  1, 32'd1};
        vecs[4] = '{4'd4, 10, 32'd24};
        vecs[5] = '{4'd13, 2, 32'd1932053504};
        vecs[6] = '{4'd15, 5, 32'd2004310016};

        rst = 1'b1; start = 1'b0; n_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, done, err, A, WE, WD}, '0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back table: each start lands in the IDLE cycle right after done.
        for (int i = 0; i < 7; i++) doOp(vecs[i].n, vecs[i].lat, vecs[i].expRes, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            logic [3:0] rn;
            rn = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            doOp(rn, int'($urandom_range(0, 20)), fact(int'(rn)), $sformatf("rnd%0d", i));
        end

        // start held through the op, operand changed while polling.
        accLatency = 4;
        start = 1'b1; n_in = 4'd5;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_in = 4'd3;
        waitOp(pc, q2d, dc, ec, be, cs, ov, to);
        check("hold_done", dc, 1);
        check("hold_result", result, 32'd120);
        @(negedge clk);
        check("hold_idle_busy", busy, 1'b0);
        @(negedge clk);
        check("hold_second_bus", {A, WE, WD}, {2'd0, 1'b1, 4'd3});
        start = 1'b0;
        @(negedge clk);
        waitOp(pc, q2d, dc, ec, be, cs, ov, to);
        check("hold_second_result", result, 32'd6);
        @(negedge clk);

        // done already high: polls at timer 0..MIN_WAIT, RD_RES right after.
        stubMode = 1;
        start = 1'b1; n_in = 4'd2;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        waitOp(pc, q2d, dc, ec, be, cs, ov, to);
        check("stale_polls", pc, MIN_WAIT + 1);
        check("stale_latency", q2d, 3);
        check("stale_result", result, 32'hCAFEF00D);
        @(negedge clk);

        // done never arrives: polls at timer 0..TIMEOUT, then abort.
        stubMode = 2;
        prevRes = result;
        start = 1'b1; n_in = 4'd7;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        waitOp(pc, q2d, dc, ec, be, cs, ov, to);
        check("to_finished", to, 1'b0);
        check("to_polls", pc, TIMEOUT + 1);
        check("to_err", ec, 1);
        check("to_done", dc, 0);
        check("to_overlap", ov, 1'b0);
        check("to_clr_go", cs, 1'b1);
        check("to_result_kept", result, prevRes);
        @(negedge clk);
        check("to_err_single", err, 1'b0);
        stubMode = 0;

        // Reset during POLL.
        accLatency = 50;
        start = 1'b1; n_in = 4'd6;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_in_poll", A, FACT_A_DONE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_bus", {A, WE, busy, done, err}, '0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        doOp(4'd4, 2, 32'd24, "after_rst");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
